// File: rtl/wb_arbiter.sv
// Writeback arbiter: two independent round-robin channels (scalar, matrix). Each channel
// merges two 1-entry completion buffers onto one registered writeback bus per cycle.

module wb_arb_slot #(
   parameter int P_W = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           valid_i,
   input  logic [P_W-1:0] pay_i,
   input  logic           spec_i,
   input  logic           miss_i,
   input  logic           resolved_i,
   input  logic           gnt_i,
   output logic           cand_o,
   output logic [P_W-1:0] cand_pay_o,
   output logic           ready_o
);
   logic           v_q, v_d;
   logic           spec_q, spec_d;
   logic [P_W-1:0] pay_q, pay_d;
   logic           in_live_s;

   assign ready_o = ~v_q | gnt_i;

   // Arbitration candidate: the held entry, else the incoming completion bypassing the buffer
   always_comb begin
      in_live_s = valid_i & ~(miss_i & spec_i);
      if (v_q) begin
         cand_o     = ~(miss_i & spec_q);
         cand_pay_o = pay_q;
      end else begin
         cand_o     = in_live_s;
         cand_pay_o = pay_i;
      end
   end

   // Buffer next state: hold while losing, otherwise capture whatever did not bypass
   always_comb begin
      v_d    = v_q;
      spec_d = spec_q & ~resolved_i;
      pay_d  = pay_q;
      if (v_q && !gnt_i) begin
         v_d = ~(miss_i & spec_q);
      end else begin
         v_d    = in_live_s & ~(~v_q & gnt_i);
         spec_d = spec_i & ~resolved_i;
         pay_d  = pay_i;
      end
   end

   // Buffer registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v_q    <= 1'b0;
         spec_q <= 1'b0;
         pay_q  <= {P_W{1'b0}};
      end else begin
         v_q    <= v_d;
         spec_q <= spec_d;
         pay_q  <= pay_d;
      end
   end
endmodule

module wb_arb_chan #(
   parameter int P_W = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           a_valid_i,
   input  logic [P_W-1:0] a_pay_i,
   input  logic           a_spec_i,
   input  logic           b_valid_i,
   input  logic [P_W-1:0] b_pay_i,
   input  logic           b_spec_i,
   input  logic           miss_i,
   input  logic           resolved_i,
   output logic           a_ready_o,
   output logic           b_ready_o,
   output logic           wb_en_o,
   output logic [1:0]     wb_code_o,
   output logic [P_W-1:0] wb_pay_o
);
   localparam logic [1:0] CODE_NONE = 2'd0;
   localparam logic [1:0] CODE_A    = 2'd1;
   localparam logic [1:0] CODE_B    = 2'd2;

   logic           a_cand_s, b_cand_s;
   logic [P_W-1:0] a_cpay_s, b_cpay_s;
   logic           gnt_a_s, gnt_b_s;
   logic           prio_q, prio_d;
   logic           en_q, en_d;
   logic [1:0]     code_q, code_d;
   logic [P_W-1:0] pay_q, pay_d;

   wb_arb_slot #(.P_W(P_W)) u_slot_a (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (a_valid_i),
      .pay_i      (a_pay_i),
      .spec_i     (a_spec_i),
      .miss_i     (miss_i),
      .resolved_i (resolved_i),
      .gnt_i      (gnt_a_s),
      .cand_o     (a_cand_s),
      .cand_pay_o (a_cpay_s),
      .ready_o    (a_ready_o)
   );

   wb_arb_slot #(.P_W(P_W)) u_slot_b (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (b_valid_i),
      .pay_i      (b_pay_i),
      .spec_i     (b_spec_i),
      .miss_i     (miss_i),
      .resolved_i (resolved_i),
      .gnt_i      (gnt_b_s),
      .cand_o     (b_cand_s),
      .cand_pay_o (b_cpay_s),
      .ready_o    (b_ready_o)
   );

   // Round-robin grant; prio_q=1 means side B was not granted last
   always_comb begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
      if (a_cand_s && b_cand_s) begin
         gnt_a_s = ~prio_q;
         gnt_b_s = prio_q;
      end else begin
         gnt_a_s = a_cand_s;
         gnt_b_s = b_cand_s;
      end
   end

   // Output register and pointer next state; rd/data hold when nothing is granted
   always_comb begin
      prio_d = prio_q;
      en_d   = gnt_a_s | gnt_b_s;
      code_d = CODE_NONE;
      pay_d  = pay_q;
      if (gnt_a_s) begin
         prio_d = 1'b1;
         code_d = CODE_A;
         pay_d  = a_cpay_s;
      end else if (gnt_b_s) begin
         prio_d = 1'b0;
         code_d = CODE_B;
         pay_d  = b_cpay_s;
      end else begin
         code_d = CODE_NONE;
      end
   end

   // Pointer and writeback output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
         en_q   <= 1'b0;
         code_q <= CODE_NONE;
         pay_q  <= {P_W{1'b0}};
      end else begin
         prio_q <= prio_d;
         en_q   <= en_d;
         code_q <= code_d;
         pay_q  <= pay_d;
      end
   end

   assign wb_en_o   = en_q;
   assign wb_code_o = code_q;
   assign wb_pay_o  = pay_q;
endmodule

module wb_arbiter #(
   parameter int WORD_W  = 32,
   parameter int S_REG_W = 5,
   parameter int M_REG_W = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               alu_valid,
   output logic               alu_ready,
   input  logic [S_REG_W-1:0] alu_rd,
   input  logic [WORD_W-1:0]  alu_data,
   input  logic               alu_spec,
   input  logic               sls_valid,
   output logic               sls_ready,
   input  logic [S_REG_W-1:0] sls_rd,
   input  logic [WORD_W-1:0]  sls_data,
   input  logic               sls_spec,
   input  logic               mls_valid,
   output logic               mls_ready,
   input  logic [M_REG_W-1:0] mls_rd,
   input  logic               mls_spec,
   input  logic               gemm_valid,
   output logic               gemm_ready,
   input  logic [M_REG_W-1:0] gemm_rd,
   input  logic               gemm_spec,
   input  logic               branch_miss,
   input  logic               branch_resolved,
   output logic               s_rw_en,
   output logic [S_REG_W-1:0] s_rw,
   output logic [WORD_W-1:0]  s_wdat,
   output logic               m_rw_en,
   output logic [M_REG_W-1:0] m_rw,
   output logic [1:0]         fu_ex,
   output logic [1:0]         fu_mx
);
   localparam int SP_W = S_REG_W + WORD_W;

   logic [SP_W-1:0] s_pay_s;

   // Scalar: side A is the ALU (code 1), side B the scalar load/store (code 2)
   wb_arb_chan #(.P_W(SP_W)) u_scalar (
      .clk_i      (CLK),
      .rst_i      (RST),
      .a_valid_i  (alu_valid),
      .a_pay_i    ({alu_rd, alu_data}),
      .a_spec_i   (alu_spec),
      .b_valid_i  (sls_valid),
      .b_pay_i    ({sls_rd, sls_data}),
      .b_spec_i   (sls_spec),
      .miss_i     (branch_miss),
      .resolved_i (branch_resolved),
      .a_ready_o  (alu_ready),
      .b_ready_o  (sls_ready),
      .wb_en_o    (s_rw_en),
      .wb_code_o  (fu_ex),
      .wb_pay_o   (s_pay_s)
   );

   // Matrix: side A is GEMM (code 1), side B the matrix load/store (code 2)
   wb_arb_chan #(.P_W(M_REG_W)) u_matrix (
      .clk_i      (CLK),
      .rst_i      (RST),
      .a_valid_i  (gemm_valid),
      .a_pay_i    (gemm_rd),
      .a_spec_i   (gemm_spec),
      .b_valid_i  (mls_valid),
      .b_pay_i    (mls_rd),
      .b_spec_i   (mls_spec),
      .miss_i     (branch_miss),
      .resolved_i (branch_resolved),
      .a_ready_o  (gemm_ready),
      .b_ready_o  (mls_ready),
      .wb_en_o    (m_rw_en),
      .wb_code_o  (fu_mx),
      .wb_pay_o   (m_rw)
   );

   assign s_rw   = s_pay_s[SP_W-1:WORD_W];
   assign s_wdat = s_pay_s[WORD_W-1:0];
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vector table plus hand-written reset and data sequences.

module tb_wb_arbiter;
   localparam int WORD_W  = 32;
   localparam int S_REG_W = 5;
   localparam int M_REG_W = 4;

   logic               CLK = 1'b0;
   logic               RST;
   logic               alu_valid, alu_ready, alu_spec;
   logic [S_REG_W-1:0] alu_rd;
   logic [WORD_W-1:0]  alu_data;
   logic               sls_valid, sls_ready, sls_spec;
   logic [S_REG_W-1:0] sls_rd;
   logic [WORD_W-1:0]  sls_data;
   logic               mls_valid, mls_ready, mls_spec;
   logic [M_REG_W-1:0] mls_rd;
   logic               gemm_valid, gemm_ready, gemm_spec;
   logic [M_REG_W-1:0] gemm_rd;
   logic               branch_miss, branch_resolved;
   logic               s_rw_en, m_rw_en;
   logic [S_REG_W-1:0] s_rw;
   logic [WORD_W-1:0]  s_wdat;
   logic [M_REG_W-1:0] m_rw;
   logic [1:0]         fu_ex, fu_mx;

   always #5 CLK = ~CLK;

   wb_arbiter #(.WORD_W(WORD_W), .S_REG_W(S_REG_W), .M_REG_W(M_REG_W)) dut (
      .CLK(CLK), .RST(RST),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data), .alu_spec(alu_spec),
      .sls_valid(sls_valid), .sls_ready(sls_ready), .sls_rd(sls_rd), .sls_data(sls_data), .sls_spec(sls_spec),
      .mls_valid(mls_valid), .mls_ready(mls_ready), .mls_rd(mls_rd), .mls_spec(mls_spec),
      .gemm_valid(gemm_valid), .gemm_ready(gemm_ready), .gemm_rd(gemm_rd), .gemm_spec(gemm_spec),
      .branch_miss(branch_miss), .branch_resolved(branch_resolved),
      .s_rw_en(s_rw_en), .s_rw(s_rw), .s_wdat(s_wdat),
      .m_rw_en(m_rw_en), .m_rw(m_rw), .fu_ex(fu_ex), .fu_mx(fu_mx)
   );

   // ctl = {rst, miss, resolved}; source byte = {valid, spec, -, rd};
   // expected byte = {en, code[1:0], rw}; rdy = {alu, sls, gemm, mls}
   typedef struct {
      logic [2:0] ctl;
      logic [7:0] alu, sls, gemm, mls;
      logic [7:0] s_exp, m_exp;
      logic [3:0] rdy;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic [2:0] ctl, input logic [7:0] alu, input logic [7:0] sls,
                               input logic [7:0] gemm, input logic [7:0] mls,
                               input logic [7:0] s_exp, input logic [7:0] m_exp, input logic [3:0] rdy);
      vec_t v;
      v.ctl = ctl; v.alu = alu; v.sls = sls; v.gemm = gemm; v.mls = mls;
      v.s_exp = s_exp; v.m_exp = m_exp; v.rdy = rdy;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      RST = 1'b0; branch_miss = 1'b0; branch_resolved = 1'b0;
      alu_valid = 1'b0; alu_spec = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      sls_valid = 1'b0; sls_spec = 1'b0; sls_rd = 5'd0; sls_data = 32'd0;
      gemm_valid = 1'b0; gemm_spec = 1'b0; gemm_rd = 4'd0;
      mls_valid = 1'b0; mls_spec = 1'b0; mls_rd = 4'd0;
   endtask

   task automatic apply(input vec_t v);
      RST = v.ctl[2]; branch_miss = v.ctl[1]; branch_resolved = v.ctl[0];
      alu_valid = v.alu[7]; alu_spec = v.alu[6]; alu_rd = v.alu[4:0];
      alu_data = 32'hA000_0000 | {27'd0, v.alu[4:0]};
      sls_valid = v.sls[7]; sls_spec = v.sls[6]; sls_rd = v.sls[4:0];
      sls_data = 32'h5A00_0000 | {27'd0, v.sls[4:0]};
      gemm_valid = v.gemm[7]; gemm_spec = v.gemm[6]; gemm_rd = v.gemm[3:0];
      mls_valid = v.mls[7]; mls_spec = v.mls[6]; mls_rd = v.mls[3:0];
   endtask

   task automatic check_row(input int i, input vec_t v);
      logic [31:0] wexp;
      check($sformatf("r%0d s_rw_en", i), {31'd0, s_rw_en}, {31'd0, v.s_exp[7]});
      check($sformatf("r%0d fu_ex", i), {30'd0, fu_ex}, {30'd0, v.s_exp[6:5]});
      if (v.s_exp[7]) begin
         wexp = (v.s_exp[6:5] == 2'd1) ? 32'hA000_0000 : 32'h5A00_0000;
         wexp = wexp | {27'd0, v.s_exp[4:0]};
         check($sformatf("r%0d s_rw", i), {27'd0, s_rw}, {27'd0, v.s_exp[4:0]});
         check($sformatf("r%0d s_wdat", i), s_wdat, wexp);
      end
      check($sformatf("r%0d m_rw_en", i), {31'd0, m_rw_en}, {31'd0, v.m_exp[7]});
      check($sformatf("r%0d fu_mx", i), {30'd0, fu_mx}, {30'd0, v.m_exp[6:5]});
      if (v.m_exp[7]) begin
         check($sformatf("r%0d m_rw", i), {28'd0, m_rw}, {28'd0, v.m_exp[3:0]});
      end
      check($sformatf("r%0d ready", i), {28'd0, alu_ready, sls_ready, gemm_ready, mls_ready},
            {28'd0, v.rdy});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " s_rw_en"}, {31'd0, s_rw_en}, 32'd0);
      check({tag, " s_rw"}, {27'd0, s_rw}, 32'd0);
      check({tag, " s_wdat"}, s_wdat, 32'd0);
      check({tag, " fu_ex"}, {30'd0, fu_ex}, 32'd0);
      check({tag, " m_rw_en"}, {31'd0, m_rw_en}, 32'd0);
      check({tag, " m_rw"}, {28'd0, m_rw}, 32'd0);
      check({tag, " fu_mx"}, {30'd0, fu_mx}, 32'd0);
      check({tag, " ready"}, {28'd0, alu_ready, sls_ready, gemm_ready, mls_ready}, 32'hF);
   endtask

   initial begin
      // Contention, backpressure and matrix mispredict (both pointers at reset side)
      vecs.push_back(mk(3'b000, 8'h83, 8'h84, 8'h81, 8'h89, 8'h00, 8'h00, 4'hF));
      vecs.push_back(mk(3'b000, 8'h8A, 8'h8B, 8'hC2, 8'h87, 8'hA3, 8'hA1, 4'hF));
      vecs.push_back(mk(3'b010, 8'h8C, 8'h00, 8'h00, 8'h00, 8'hC4, 8'hC9, 4'h9));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hC7, 4'h7));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'hCB, 8'h00, 4'hF));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAC, 8'h00, 4'hF));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF));
      // Resolve on the buffering cycle, miss next cycle: entries survive
      vecs.push_back(mk(3'b000, 8'h00, 8'h81, 8'h00, 8'h83, 8'h00, 8'h00, 4'hF));
      vecs.push_back(mk(3'b001, 8'h82, 8'hC6, 8'h84, 8'hC6, 8'hC1, 8'hC3, 4'hF));
      vecs.push_back(mk(3'b010, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA2, 8'hA4, 4'hF));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC6, 8'hC6, 4'hF));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF));
      // Miss+resolve same cycle drops buffered spec entry; spec inputs discarded
      vecs.push_back(mk(3'b000, 8'h82, 8'hC8, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF));
      vecs.push_back(mk(3'b011, 8'hC9, 8'h00, 8'hC5, 8'h81, 8'hA2, 8'h00, 4'hB));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC1, 4'hF));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF));
      // Pointer unchanged by the grant-less cycle: SLS wins, GEMM wins
      vecs.push_back(mk(3'b000, 8'h81, 8'h82, 8'h88, 8'h8A, 8'h00, 8'h00, 4'hF));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC2, 8'hA8, 4'hF));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hCA, 4'hF));
      vecs.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF));

      idle();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #2 RST = 1'b0;
      #4 check_all_zero("init");

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge CLK);
         #2 apply(vecs[i]);
         #4 check_row(i, vecs[i]);
      end

      // Fill all four buffers, then reset mid-stream
      @(posedge CLK);
      #2 idle();
      alu_valid = 1'b1; alu_rd = 5'd1; sls_valid = 1'b1; sls_rd = 5'd2;
      gemm_valid = 1'b1; gemm_rd = 4'd3; mls_valid = 1'b1; mls_rd = 4'd4;
      @(posedge CLK);
      #2 alu_rd = 5'd5; sls_rd = 5'd6; gemm_rd = 4'd7; mls_rd = 4'd8;
      @(posedge CLK);
      #2 idle();
      RST = 1'b1;
      #4 check("bp scalar one ready", {31'd0, alu_ready ^ sls_ready}, 32'd1);
      check("bp matrix one ready", {31'd0, gemm_ready ^ mls_ready}, 32'd1);
      @(posedge CLK);
      #2 RST = 1'b0;
      #4 check_all_zero("rst_mid");
      for (int k = 0; k < 2; k++) begin
         @(posedge CLK);
         #6 check($sformatf("post_rst%0d s_rw_en", k), {31'd0, s_rw_en}, 32'd0);
         check($sformatf("post_rst%0d m_rw_en", k), {31'd0, m_rw_en}, 32'd0);
      end

      // Single ALU completion with full data word, then hold of rw/wdat
      @(posedge CLK);
      #2 alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; alu_spec = 1'b0;
      @(posedge CLK);
      #2 idle();
      #4 check("single s_rw_en", {31'd0, s_rw_en}, 32'd1);
      check("single s_rw", {27'd0, s_rw}, 32'd5);
      check("single s_wdat", s_wdat, 32'hDEAD_BEEF);
      check("single fu_ex", {30'd0, fu_ex}, 32'd1);
      @(posedge CLK);
      #6 check("single2 s_rw_en", {31'd0, s_rw_en}, 32'd0);
      check("single2 fu_ex", {30'd0, fu_ex}, 32'd0);
      check("single2 s_rw hold", {27'd0, s_rw}, 32'd5);
      check("single2 s_wdat hold", s_wdat, 32'hDEAD_BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and completion buffer for the scalar and matrix result paths. It sits between the execute-stage functional units (scalar ALU, scalar load/store, matrix load/store, GEMM) and the register files. It serialises completions onto one scalar and one matrix writeback bus per cycle, and drives the writeback and done codes that dispatch uses to free register-status-table entries and clear FUST tags. It also drops speculative completions on a branch mispredict.

## Interface
- WORD_W, 32, scalar data width
- S_REG_W, 5, scalar register index width
- M_REG_W, 4, matrix register index width
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- alu_valid / alu_ready  in / out  1  ALU completion handshake
- alu_rd, alu_data, alu_spec  in  S_REG_W, WORD_W, 1  ALU result and speculative flag
- sls_valid / sls_ready  in / out  1  scalar load completion handshake
- sls_rd, sls_data, sls_spec  in  S_REG_W, WORD_W, 1  load result and speculative flag
- mls_valid / mls_ready  in / out  1  matrix load completion handshake
- mls_rd, mls_spec  in  M_REG_W, 1  matrix load destination and speculative flag
- gemm_valid / gemm_ready  in / out  1  GEMM completion handshake
- gemm_rd, gemm_spec  in  M_REG_W, 1  GEMM destination and speculative flag
- branch_miss  in  1  mispredict; squash speculative entries
- branch_resolved  in  1  branch correct; speculative entries become non-speculative
- s_rw_en, s_rw, s_wdat  out  1, S_REG_W, WORD_W  scalar writeback bus
- m_rw_en, m_rw  out  1, M_REG_W  matrix writeback bus
- fu_ex  out  2  scalar done code: 0 NONE, 1 ALU_DONE, 2 SCALAR_LS_DONE
- fu_mx  out  2  matrix done code: 0 NONE, 1 GEMM_DONE, 2 MATRIX_LS_DONE

## Operation
- Each source has one 1-entry buffer holding {valid, rd, data (scalar only), spec}.
- A transfer occurs when valid && ready.
- ready = ~buf_valid | granted-this-cycle. A granted entry drains and the buffer may refill in the same cycle.
- Scalar arbiter: picks between ALU and SLS buffers. Matrix arbiter: picks between GEMM and MLS buffers. Both are independent.
- Round-robin rules:
  - If one side is valid, it wins.
  - If both are valid, the side not granted last wins.
  - The pointer updates only on an actual grant.
  - Reset favours ALU (scalar) and GEMM (matrix).
- The granted entry loads the output register. Outputs are the registered copy:
  - s_rw_en=1, s_rw=rd, s_wdat=data, fu_ex=source code.
  - Matrix outputs are analogous.
  - With no grant, s_rw_en=0 and fu_ex=NONE; rw/wdat hold their last value.
- branch_miss:
  - Every buffered entry with spec=1 is invalidated.
  - A spec=1 input transferring that cycle is accepted (ready unaffected) and discarded.
  - A spec=1 entry selected that cycle is not granted. The arbiter regrants this cycle among the surviving non-spec entries.
  - Output registers already loaded are unaffected.
- branch_resolved: clears spec in all buffers and on the entry being written that cycle.
- branch_miss and branch_resolved in the same cycle: branch_miss wins.
- No rd conflict checking; WAW is prevented upstream at dispatch.

## Timing
- Latency: a transfer in cycle N with an empty buffer and no contention produces writeback outputs asserted in cycle N+1.
- Each loser of arbitration adds 1 cycle of delay.
- Throughput: 1 scalar and 1 matrix writeback per cycle. Sustained single-source streaming keeps ready=1 every cycle.
- Reset (RST=1 at a clock edge) forces the following to 0, and sets both round-robin pointers to their reset side:
  - all buffers invalid;
  - s_rw_en, m_rw_en, s_rw, m_rw, s_wdat;
  - fu_ex=NONE, fu_mx=NONE.
- Reset mid-operation discards all pending completions.
- ready outputs are combinational from buffer state and grant. They never depend combinationally on the same source's valid.
- After reset, all ready outputs = 1.

## Test plan
- Single ALU: alu_valid=1, rd=5, data=0xDEADBEEF, spec=0 in cycle 0 -> cycle 1 shows s_rw_en=1, s_rw=5, s_wdat=0xDEADBEEF, fu_ex=1; cycle 2 shows s_rw_en=0, fu_ex=0.
- Contention: ALU rd=3 and SLS rd=4 both valid in cycle 0 -> cycle 1 shows rd=3 with fu_ex=1, cycle 2 shows rd=4 with fu_ex=2.
  - Repeating the pair next time -> SLS wins first.
  - Backpressure: alu_ready=0 while the ALU buffer is held.
- Mispredict: GEMM spec=1 (rd=2) and MLS spec=0 (rd=7) buffered while the matrix output is busy, then branch_miss -> only rd=7 is written back with fu_mx=2; rd=2 never appears.
- Resolve: buffered SLS spec=1, branch_resolved pulse, then branch_miss 2 cycles later -> the SLS entry is still written back.
- Same-cycle miss and resolve with a spec entry buffered -> entry dropped.
- Reset mid-stream: RST asserted with all four buffers full -> the cycle after, every output is 0 and all ready=1; no writeback occurs afterwards until new input arrives.
